// File: rtl/reg_bank_pkg.sv
// Shared definitions for the Decode-stage register file.
// Holds the geometry parameters, the zero-register constant and the read-source
// encoding. The EX-stage forwarding unit will reuse the same encoding.
package reg_bank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Where a read port takes its data from.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_MEM   = 2'd1,
        SRC_WB    = 2'd2,
        SRC_ARRAY = 2'd3
    } src_sel_e;

    // Source selection in priority order: zero register, MEM, WB, array.
    function automatic src_sel_e fwd_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              mem_hit,
        input logic              wb_hit
    );
        src_sel_e sel;
        if (addr == REG_ZERO) begin
            sel = SRC_ZERO;
        end else if (mem_hit) begin
            sel = SRC_MEM;
        end else if (wb_hit) begin
            sel = SRC_WB;
        end else begin
            sel = SRC_ARRAY;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One register-file read port: address-to-data mux with bypass priority.
// Ports:
//   i_reset        forces the output to zero while high
//   i_addr         register address being read
//   i_arr_data     array contents at i_addr
//   i_mem_*        EX/MEM forwarding source (only used when FORWARD != 0)
//   i_wen          the Writeback write is actually happening this cycle
//   i_wb_regdest   Writeback destination register
//   i_wb_data      Writeback data
//   o_data         selected read data
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter bit FORWARD = 1'b0
) (
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_arr_data,
    input  logic              i_mem_writereg,
    input  logic [ADDR_W-1:0] i_mem_regdest,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_wb_regdest,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    logic     w_mem_hit;
    logic     w_wb_hit;
    src_sel_e w_sel;

    // The MEM leg is tied off on plain ports so the WB bypass is their only source.
    assign w_mem_hit = FORWARD && i_mem_writereg && (i_mem_regdest == i_addr);
    // i_wen already excludes overflow-suppressed writes, so those are never bypassed.
    assign w_wb_hit  = i_wen && (i_wb_regdest == i_addr);
    assign w_sel     = fwd_sel(i_addr, w_mem_hit, w_wb_hit);

    // Output mux; reset overrides every source.
    always_comb begin
        o_data = {DATA_W{1'b0}};
        if (i_reset) begin
            o_data = {DATA_W{1'b0}};
        end else begin
            case (w_sel)
                SRC_ZERO:  o_data = {DATA_W{1'b0}};
                SRC_MEM:   o_data = i_mem_data;
                SRC_WB:    o_data = i_wb_data;
                SRC_ARRAY: o_data = i_arr_data;
                default:   o_data = {DATA_W{1'b0}};
            endcase
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32x32 register file serving the Decode stage.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   id_reg_addra/addrb      read addresses
//   reg_id_dataa/datab      plain reads with Writeback write-through
//   reg_id_ass_dataa/datab  forwarded reads (MEM > WB > array) for branch/jr
//   mem_reg_*               EX/MEM forwarding source
//   wb_reg_*                Writeback write port with overflow gating
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_reg_addra,
    input  logic [ADDR_W-1:0] id_reg_addrb,
    output logic [DATA_W-1:0] reg_id_dataa,
    output logic [DATA_W-1:0] reg_id_datab,
    output logic [DATA_W-1:0] reg_id_ass_dataa,
    output logic [DATA_W-1:0] reg_id_ass_datab,
    input  logic [ADDR_W-1:0] mem_reg_regdest,
    input  logic              mem_reg_writereg,
    input  logic [DATA_W-1:0] mem_reg_data,
    input  logic [ADDR_W-1:0] wb_reg_regdest,
    input  logic              wb_reg_writereg,
    input  logic              wb_reg_writeov,
    input  logic              wb_reg_overflow,
    input  logic [DATA_W-1:0] wb_reg_data
);

    logic [DATA_W-1:0] r_mem [0:NREGS-1];
    logic              w_wen;
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;

    // Overflowing signed ops do not commit unless the op is flagged as unsigned;
    // register 0 is never written so it stays zero without special read logic.
    assign w_wen = wb_reg_writereg & (~wb_reg_overflow | wb_reg_writeov)
                 & (wb_reg_regdest != REG_ZERO);

    assign w_arr_a = r_mem[id_reg_addra];
    assign w_arr_b = r_mem[id_reg_addrb];

    // Array update: reset clears every entry in one edge and beats a pending write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wen) begin
            r_mem[wb_reg_regdest] <= wb_reg_data;
        end
    end

    reg_read_port #(.FORWARD(1'b0)) u_port_a (
        .i_reset(reset), .i_addr(id_reg_addra), .i_arr_data(w_arr_a),
        .i_mem_writereg(mem_reg_writereg), .i_mem_regdest(mem_reg_regdest),
        .i_mem_data(mem_reg_data), .i_wen(w_wen), .i_wb_regdest(wb_reg_regdest),
        .i_wb_data(wb_reg_data), .o_data(reg_id_dataa)
    );

    reg_read_port #(.FORWARD(1'b0)) u_port_b (
        .i_reset(reset), .i_addr(id_reg_addrb), .i_arr_data(w_arr_b),
        .i_mem_writereg(mem_reg_writereg), .i_mem_regdest(mem_reg_regdest),
        .i_mem_data(mem_reg_data), .i_wen(w_wen), .i_wb_regdest(wb_reg_regdest),
        .i_wb_data(wb_reg_data), .o_data(reg_id_datab)
    );

    reg_read_port #(.FORWARD(1'b1)) u_port_ass_a (
        .i_reset(reset), .i_addr(id_reg_addra), .i_arr_data(w_arr_a),
        .i_mem_writereg(mem_reg_writereg), .i_mem_regdest(mem_reg_regdest),
        .i_mem_data(mem_reg_data), .i_wen(w_wen), .i_wb_regdest(wb_reg_regdest),
        .i_wb_data(wb_reg_data), .o_data(reg_id_ass_dataa)
    );

    reg_read_port #(.FORWARD(1'b1)) u_port_ass_b (
        .i_reset(reset), .i_addr(id_reg_addrb), .i_arr_data(w_arr_b),
        .i_mem_writereg(mem_reg_writereg), .i_mem_regdest(mem_reg_regdest),
        .i_mem_data(mem_reg_data), .i_wen(w_wen), .i_wb_regdest(wb_reg_regdest),
        .i_wb_data(wb_reg_data), .o_data(reg_id_ass_datab)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with fixed expectations,
// then a random phase checked against a small reference model. Expectations are
// queued when inputs are driven and compared on the following falling edge.
module tb_reg_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_reg_addra, id_reg_addrb;
    logic [31:0] reg_id_dataa, reg_id_datab, reg_id_ass_dataa, reg_id_ass_datab;
    logic [4:0]  mem_reg_regdest;
    logic        mem_reg_writereg;
    logic [31:0] mem_reg_data;
    logic [4:0]  wb_reg_regdest;
    logic        wb_reg_writereg, wb_reg_writeov, wb_reg_overflow;
    logic [31:0] wb_reg_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] aa;
        logic [31:0] ab;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] model_regs [32];

    reg_bank dut (
        .clock(clock), .reset(reset),
        .id_reg_addra(id_reg_addra), .id_reg_addrb(id_reg_addrb),
        .reg_id_dataa(reg_id_dataa), .reg_id_datab(reg_id_datab),
        .reg_id_ass_dataa(reg_id_ass_dataa), .reg_id_ass_datab(reg_id_ass_datab),
        .mem_reg_regdest(mem_reg_regdest), .mem_reg_writereg(mem_reg_writereg),
        .mem_reg_data(mem_reg_data), .wb_reg_regdest(wb_reg_regdest),
        .wb_reg_writereg(wb_reg_writereg), .wb_reg_writeov(wb_reg_writeov),
        .wb_reg_overflow(wb_reg_overflow), .wb_reg_data(wb_reg_data)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the write enable and both read flavours.
    function automatic logic m_wen();
        return wb_reg_writereg && (!wb_reg_overflow || wb_reg_writeov) && (wb_reg_regdest != 5'd0);
    endfunction

    function automatic logic [31:0] m_plain(input logic [4:0] addr);
        if (reset || addr == 5'd0) return 32'd0;
        if (m_wen() && wb_reg_regdest == addr) return wb_reg_data;
        return model_regs[addr];
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] addr);
        if (reset || addr == 5'd0) return 32'd0;
        if (mem_reg_writereg && mem_reg_regdest == addr) return mem_reg_data;
        if (m_wen() && wb_reg_regdest == addr) return wb_reg_data;
        return model_regs[addr];
    endfunction

    // Optionally queue an expectation, then advance one clock and update the model.
    task automatic cycle(input string tag, input bit do_chk,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] eaa, input logic [31:0] eab);
        exp_t e;
        if (do_chk) begin
            e.tag = tag; e.a = ea; e.b = eb; e.aa = eaa; e.ab = eab;
            sb_q.push_back(e);
        end
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        end else if (m_wen()) begin
            model_regs[wb_reg_regdest] = wb_reg_data;
        end
        #1;
    endtask

    task automatic idle_inputs();
        mem_reg_writereg = 1'b0; mem_reg_regdest = 5'd0; mem_reg_data = 32'd0;
        wb_reg_writereg = 1'b0; wb_reg_regdest = 5'd0; wb_reg_data = 32'd0;
        wb_reg_writeov = 1'b0; wb_reg_overflow = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] dest, input logic [31:0] data,
                            input logic ov, input logic wov);
        wb_reg_writereg = 1'b1; wb_reg_regdest = dest; wb_reg_data = data;
        wb_reg_overflow = ov; wb_reg_writeov = wov;
    endtask

    // Scoreboard consumer: compare away from the rising edge.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_value({e.tag, ".dataa"},     reg_id_dataa,     e.a);
            check_value({e.tag, ".datab"},     reg_id_datab,     e.b);
            check_value({e.tag, ".ass_dataa"}, reg_id_ass_dataa, e.aa);
            check_value({e.tag, ".ass_datab"}, reg_id_ass_datab, e.ab);
        end
    end

    initial begin
        reset = 1'b1;
        id_reg_addra = 5'd5; id_reg_addrb = 5'd9;
        idle_inputs();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

        // 1. Outputs forced to zero while reset is high, then cleared array sweep.
        cycle("rst_hold", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            id_reg_addra = 5'(i); id_reg_addrb = 5'(31 - i);
            cycle("rst_sweep", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // 2. Write and read back; writes to r0 are discarded.
        wb_write(5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle("w5", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_inputs();
        id_reg_addra = 5'd5; id_reg_addrb = 5'd5;
        cycle("rd5", 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wb_write(5'd0, 32'h0000_1234, 1'b0, 1'b0);
        mem_reg_writereg = 1'b1; mem_reg_regdest = 5'd0; mem_reg_data = 32'h0000_5678;
        id_reg_addra = 5'd0; id_reg_addrb = 5'd0;
        cycle("w0_thru", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_inputs();
        cycle("rd0", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);

        // 3. Write-through on port B in the cycle of the write.
        wb_write(5'd7, 32'h0000_00AA, 1'b0, 1'b0);
        id_reg_addra = 5'd5; id_reg_addrb = 5'd7;
        cycle("wthru7", 1'b1, 32'hDEAD_BEEF, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_00AA);
        idle_inputs();
        cycle("rd7", 1'b1, 32'hDEAD_BEEF, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_00AA);

        // 4. Forwarding priority MEM > WB > array.
        wb_write(5'd3, 32'h0000_0001, 1'b0, 1'b0);
        id_reg_addra = 5'd3; id_reg_addrb = 5'd7;
        cycle("w3", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_inputs();
        cycle("rd3", 1'b1, 32'h1, 32'hAA, 32'h1, 32'hAA);
        wb_write(5'd3, 32'h0000_0002, 1'b0, 1'b0);
        mem_reg_writereg = 1'b1; mem_reg_regdest = 5'd3; mem_reg_data = 32'h0000_0003;
        id_reg_addrb = 5'd3;
        cycle("fwd_mem", 1'b1, 32'h2, 32'h2, 32'h3, 32'h3);
        mem_reg_writereg = 1'b0;
        cycle("fwd_wb", 1'b1, 32'h2, 32'h2, 32'h2, 32'h2);
        idle_inputs();
        mem_reg_writereg = 1'b1; mem_reg_regdest = 5'd7; mem_reg_data = 32'h0000_0077;
        id_reg_addrb = 5'd7;
        cycle("fwd_mem_only", 1'b1, 32'h2, 32'hAA, 32'h2, 32'h77);
        idle_inputs();

        // 5. Overflow gating: suppressed write neither commits nor bypasses.
        id_reg_addra = 5'd9; id_reg_addrb = 5'd9;
        wb_write(5'd9, 32'h0000_FFFF, 1'b1, 1'b0);
        cycle("ov_block", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_inputs();
        cycle("ov_rd", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        wb_write(5'd9, 32'h0000_FFFF, 1'b1, 1'b1);
        cycle("ov_allow", 1'b1, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
        idle_inputs();
        cycle("ov_rd2", 1'b1, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);

        // 6. Reset beats a same-cycle write and clears existing contents.
        reset = 1'b1;
        wb_write(5'd4, 32'h0000_0055, 1'b0, 1'b0);
        id_reg_addra = 5'd4; id_reg_addrb = 5'd5;
        cycle("rst_w", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        idle_inputs();
        cycle("rst_w_rd", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);

        // Random traffic against the reference model; small address range for hits.
        for (int n = 0; n < 300; n++) begin
            reset            = ($urandom_range(0, 40) == 0);
            id_reg_addra     = 5'($urandom_range(0, 7));
            id_reg_addrb     = 5'($urandom_range(0, 7));
            mem_reg_writereg = 1'($urandom_range(0, 1));
            mem_reg_regdest  = 5'($urandom_range(0, 7));
            mem_reg_data     = $urandom();
            wb_reg_writereg  = 1'($urandom_range(0, 1));
            wb_reg_regdest   = 5'($urandom_range(0, 7));
            wb_reg_data      = $urandom();
            wb_reg_overflow  = 1'($urandom_range(0, 1));
            wb_reg_writeov   = 1'($urandom_range(0, 1));
            cycle("rand", 1'b1, m_plain(id_reg_addra), m_plain(id_reg_addrb),
                  m_fwd(id_reg_addra), m_fwd(id_reg_addrb));
        end
        reset = 1'b0;
        idle_inputs();

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clock);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
